sram_req_queue: RTL and testbench
=================================

Name: sram_req_queue

Overview:
- Request front-end that sits directly upstream of the 23K256 SPI SRAM controller. It buffers app byte read/write requests in a small FIFO.
- Issues requests to the controller strictly one at a time and holds off the next request for a fixed completion window, so the controller never merges requests into a sequential burst.
- Captures read data at completion and returns it on a valid/ready response port.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >= 2
TXN_WAIT, 640, i_clk cycles from controller accept to transaction complete; must cover one full single-byte SPI transaction at the controller's clock divider
CW, $clog2(TXN_WAIT), wait counter width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_req_addr  in  15  app request address
i_req_data  in  8  app write data
i_req_rnw  in  1  1=read, 0=write
i_req_valid  in  1  app request valid
o_req_ready  out  1  FIFO has space
o_rsp_data  out  8  read data returned
o_rsp_valid  out  1  read response valid
i_rsp_ready  in  1  app takes response
o_sram_addr  out  15  to controller address
o_sram_data  out  8  to controller write data
o_sram_rnw  out  1  to controller read/not-write
o_sram_valid  out  1  to controller request valid
i_sram_accept  in  1  controller accept pulse
i_sram_data  in  8  controller read data (its shift register)
o_busy  out  1  state != IDLE or FIFO non-empty
o_fifo_level  out  $clog2(DEPTH+1)  entries held

Behaviour:
- Reset (i_nrst low, asynchronous): FIFO empty, state IDLE, wait counter 0. Outputs after reset: o_rsp_data=0, o_rsp_valid=0, o_sram_valid=0, o_busy=0, o_fifo_level=0, o_req_ready=1.
- FIFO:
  - Push on i_req_valid & o_req_ready, storing {addr, data, rnw}.
  - o_req_ready = (level != DEPTH).
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the level unchanged.
  - A push while full is impossible because ready is low; this is not an error path.
- o_sram_addr/data/rnw are driven combinationally from the FIFO head entry.
- o_sram_valid = (state == ISSUE).
- State machine:
  - IDLE: FIFO non-empty -> ISSUE next cycle.
  - ISSUE: hold o_sram_valid=1 until i_sram_accept=1. On accept: pop FIFO, latch head rnw into rnw_q, load counter = TXN_WAIT-1, -> WAIT.
  - WAIT: o_sram_valid=0. Counter decrements every cycle. At counter==0:
    - if rnw_q, register i_sram_data into o_rsp_data and -> RESP;
    - else -> IDLE.
  - RESP: o_rsp_valid=1, o_rsp_data stable. When i_rsp_ready=1, clear o_rsp_valid -> IDLE.
- Minimum spacing between two controller accepts is TXN_WAIT+2 cycles. o_sram_valid is never high during WAIT/RESP, so no back-to-back sequential addresses reach the controller.
- Responses come back in request order, reads only. Writes produce no response.
- An app push during ISSUE/WAIT/RESP is accepted while there is space.
- If i_sram_accept arrives outside ISSUE, it is ignored.
- Reset mid-transaction drops all queued requests and any pending response.

Optional Feature:
SRAM_REQ_QUEUE_STATS_EN
- Defined: adds ports o_wr_count (out, 16) and o_rd_count (out, 16), both reset to 0.
  - o_wr_count increments on each accepted write (ISSUE & accept & ~rnw).
  - o_rd_count increments on each accepted read.
  - Both counters wrap 0xFFFF -> 0x0000.
- Not defined: these ports and their counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle -> o_req_ready=1, o_sram_valid=0, o_rsp_valid=0, o_fifo_level=0.
- Push write addr 0x0010 data 0xA5 with accept returned 3 cycles after valid -> o_sram_addr=0x0010, o_sram_data=0xA5, o_sram_rnw=0. Valid drops the cycle after accept; no response; o_busy falls TXN_WAIT+1 cycles after accept.
- Push read addr 0x7FFF; model drives i_sram_data=0x3C at completion -> o_rsp_valid=1 with o_rsp_data=0x3C. Hold i_rsp_ready=0 for 10 cycles -> valid and data held; ready=1 -> valid clears next cycle.
- Push DEPTH+1=5 requests back-to-back at addrs 0x0100..0x0104 -> o_req_ready low after 4th; 5th accepted after first pop. Controller sees five separate accepts, each spaced >= TXN_WAIT+2 cycles, in order.
- Assert i_nrst low during WAIT with 2 entries queued -> level=0, o_sram_valid=0, o_rsp_valid=0 immediately; no further requests after release.
- With SRAM_REQ_QUEUE_STATS_EN: 3 writes + 2 reads -> o_wr_count=3, o_rd_count=2. Preload wr count at 0xFFFF (force) plus one write -> 0x0000.

Source files
------------

// File: rtl/sram_req_queue_if.sv
// Signal bundle for sram_req_queue: app request, read response and 23K256 controller sides.
// No logic of its own; zero latency.
// Backpressure: req_ready from the queue, rsp_ready from the app, sram_accept from the controller.
interface sram_req_queue_if;
    logic [14:0] req_addr;
    logic [7:0]  req_data;
    logic        req_rnw;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [14:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_rnw;
    logic        sram_valid;
    logic        sram_accept;
    logic [7:0]  sram_rdata;

    modport slave (
        input  req_addr, req_data, req_rnw, req_valid, rsp_ready, sram_accept, sram_rdata,
        output req_ready, rsp_data, rsp_valid, sram_addr, sram_wdata, sram_rnw, sram_valid
    );

    modport master (
        output req_addr, req_data, req_rnw, req_valid, rsp_ready, sram_accept, sram_rdata,
        input  req_ready, rsp_data, rsp_valid, sram_addr, sram_wdata, sram_rnw, sram_valid
    );
endinterface

// File: rtl/sram_req_queue.sv
// Single-request SPI SRAM front-end: FIFO-buffered, one controller request per TXN_WAIT window (SRAM_REQ_QUEUE_STATS_EN adds counters).
// Latency: request reaches the controller 2 cycles after push when idle; read response TXN_WAIT+1 cycles after accept.
// Backpressure: req_ready low while FIFO full; a held response blocks further issue until rsp_ready.
module sram_req_queue #(
    parameter  int DEPTH    = 4,
    parameter  int TXN_WAIT = 640,
    localparam int CW       = $clog2(TXN_WAIT),
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    sram_req_queue_if.slave   q_if,
    output logic              o_busy,
    output logic [LW-1:0]     o_fifo_level
`ifdef SRAM_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]       o_wr_count,
    output logic [15:0]       o_rd_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
        logic        rnw;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rnw_q;
    logic [7:0]      rsp_data_q;
    logic            push;
    logic            pop;
    req_t            head;

    assign head           = mem_q[rd_ptr_q];
    assign q_if.req_ready = (level_q != LW'(DEPTH));
    assign push           = q_if.req_valid & q_if.req_ready;
    assign pop            = (state_q == ISSUE) & q_if.sram_accept;

    assign q_if.sram_addr  = head.addr;
    assign q_if.sram_wdata = head.data;
    assign q_if.sram_rnw   = head.rnw;
    assign q_if.sram_valid = (state_q == ISSUE);
    assign q_if.rsp_valid  = (state_q == RESP);
    assign q_if.rsp_data   = rsp_data_q;
    assign o_busy          = (state_q != IDLE) | (level_q != '0);
    assign o_fifo_level    = level_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{addr: q_if.req_addr, data: q_if.req_data, rnw: q_if.req_rnw};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    // The WAIT window keeps sram_valid low long enough that the controller
    // finishes each byte before seeing the next, so it never forms a burst.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rnw_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level_q != '0) state_q <= ISSUE;
                end
                ISSUE: begin
                    if (q_if.sram_accept) begin
                        rnw_q   <= head.rnw;
                        cnt_q   <= CW'(TXN_WAIT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (rnw_q) begin
                            rsp_data_q <= q_if.sram_rdata;
                            state_q    <= RESP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (q_if.rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SRAM_REQ_QUEUE_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else if (pop) begin
            if (head.rnw) rd_count_q <= rd_count_q + 16'd1;
            else          wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign o_wr_count = wr_count_q;
    assign o_rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_sram_req_queue.sv
// Directed self-checking bench for sram_req_queue; covers SRAM_REQ_QUEUE_STATS_EN when defined.
module tb_sram_req_queue;
    localparam int DEPTH = 4;
    localparam int TW    = 640;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic          busy;
    logic [LW-1:0] level;
`ifdef SRAM_REQ_QUEUE_STATS_EN
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;
`endif
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int prev   = 0;
    int hits   = 0;

    sram_req_queue_if bus();

    sram_req_queue #(.DEPTH(DEPTH), .TXN_WAIT(TW)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .q_if         (bus.slave),
        .o_busy       (busy),
        .o_fifo_level (level)
`ifdef SRAM_REQ_QUEUE_STATS_EN
        ,
        .o_wr_count   (wr_cnt),
        .o_rd_count   (rd_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sram_valid(input string tag);
        int k = 0;
        while (bus.sram_valid !== 1'b1 && k < TW + 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.sram_valid), 32'd1);
    endtask

`ifdef SRAM_REQ_QUEUE_STATS_EN
    task automatic do_txn(input logic [14:0] a, input logic [7:0] d, input logic r);
        int k = 0;
        bus.req_addr = a; bus.req_data = d; bus.req_rnw = r; bus.req_valid = 1'b1;
        tick(1);
        bus.req_valid = 1'b0;
        wait_sram_valid("st_valid");
        bus.sram_accept = 1'b1;
        tick(1);
        bus.sram_accept = 1'b0;
        while (busy !== 1'b0 && k < TW + 20) begin
            @(negedge clk);
            k++;
        end
        chk("st_done", 32'(busy), 32'd0);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.req_addr = '0; bus.req_data = '0; bus.req_rnw = 1'b0; bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0; bus.sram_accept = 1'b0; bus.sram_rdata = '0;
        tick(3);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_sram_valid", 32'(bus.sram_valid), 32'd0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rst_rsp_data",   32'(bus.rsp_data),   32'd0);
        chk("rst_level",      32'(level),          32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        nrst = 1'b1;
        tick(3);
        chk("idle_sram_valid", 32'(bus.sram_valid), 32'd0);
        chk("idle_req_ready",  32'(bus.req_ready),  32'd1);

        // Single write, accept returned 3 cycles after valid rises
        bus.req_addr = 15'h0010; bus.req_data = 8'hA5; bus.req_rnw = 1'b0; bus.req_valid = 1'b1;
        tick(1);
        bus.req_valid = 1'b0;
        chk("wr_level", 32'(level), 32'd1);
        chk("wr_busy",  32'(busy),  32'd1);
        tick(1);
        chk("wr_valid", 32'(bus.sram_valid), 32'd1);
        chk("wr_addr",  32'(bus.sram_addr),  32'h0010);
        chk("wr_data",  32'(bus.sram_wdata), 32'hA5);
        chk("wr_rnw",   32'(bus.sram_rnw),   32'd0);
        tick(3);
        chk("wr_valid_held", 32'(bus.sram_valid), 32'd1);
        bus.sram_accept = 1'b1;
        tick(1);
        bus.sram_accept = 1'b0;
        chk("wr_valid_drop", 32'(bus.sram_valid), 32'd0);
        chk("wr_popped",     32'(level),          32'd0);
        tick(TW - 1);
        chk("wr_busy_last", 32'(busy), 32'd1);
        tick(1);
        chk("wr_busy_fall", 32'(busy),          32'd0);
        chk("wr_no_rsp",    32'(bus.rsp_valid), 32'd0);

        // Single read with response backpressure
        bus.sram_rdata = 8'h3C;
        bus.req_addr = 15'h7FFF; bus.req_data = 8'h00; bus.req_rnw = 1'b1; bus.req_valid = 1'b1;
        tick(1);
        bus.req_valid = 1'b0;
        wait_sram_valid("rd_valid");
        chk("rd_addr", 32'(bus.sram_addr), 32'h7FFF);
        chk("rd_rnw",  32'(bus.sram_rnw),  32'd1);
        bus.sram_accept = 1'b1;
        tick(1);
        bus.sram_accept = 1'b0;
        tick(TW - 1);
        chk("rd_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick(1);
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rsp_data",  32'(bus.rsp_data),  32'h3C);
        bus.sram_rdata = 8'h00;
        tick(10);
        chk("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_hold_data",  32'(bus.rsp_data),  32'h3C);
        chk("rd_hold_issue", 32'(bus.sram_valid), 32'd0);
        bus.rsp_ready = 1'b1;
        tick(1);
        bus.rsp_ready = 1'b0;
        chk("rd_rsp_clear", 32'(bus.rsp_valid), 32'd0);
        chk("rd_idle",      32'(busy),          32'd0);

        // DEPTH+1 back-to-back writes: fill, stall, then issue one per window
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 15'(16'h0100 + i); bus.req_data = 8'(i); bus.req_rnw = 1'b0;
            bus.req_valid = 1'b1;
            tick(1);
        end
        chk("burst_full_level", 32'(level),         32'd4);
        chk("burst_full_ready", 32'(bus.req_ready), 32'd0);
        bus.req_addr = 15'h0104; bus.req_data = 8'd4;
        tick(1);
        chk("burst_full_hold", 32'(level), 32'd4);
        for (int k = 0; k < 5; k++) begin
            wait_sram_valid("burst_valid");
            chk("burst_addr", 32'(bus.sram_addr),  32'h0100 + 32'(k));
            chk("burst_data", 32'(bus.sram_wdata), 32'(k));
            if (k > 0) chk("burst_spacing", 32'(cyc - prev), 32'(TW + 2));
            prev = cyc;
            bus.sram_accept = 1'b1;
            tick(1);
            bus.sram_accept = 1'b0;
            if (k == 0) begin
                chk("burst_pop_level", 32'(level),         32'd3);
                chk("burst_pop_ready", 32'(bus.req_ready), 32'd1);
                tick(1);
                bus.req_valid = 1'b0;
                chk("burst_fifth_in", 32'(level), 32'd4);
            end
        end
        tick(TW + 2);
        chk("burst_done_busy",  32'(busy),  32'd0);
        chk("burst_done_level", 32'(level), 32'd0);

        // Reset in WAIT with two entries still queued
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 15'(16'h0200 + i); bus.req_data = 8'hEE; bus.req_rnw = 1'b0;
            bus.req_valid = 1'b1;
            tick(1);
        end
        bus.req_valid = 1'b0;
        wait_sram_valid("mrst_valid");
        bus.sram_accept = 1'b1;
        tick(1);
        bus.sram_accept = 1'b0;
        tick(5);
        chk("mrst_pre_level", 32'(level), 32'd2);
        nrst = 1'b0;
        #1;
        chk("mrst_level",      32'(level),          32'd0);
        chk("mrst_sram_valid", 32'(bus.sram_valid), 32'd0);
        chk("mrst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("mrst_busy",       32'(busy),           32'd0);
        chk("mrst_req_ready",  32'(bus.req_ready),  32'd1);
        tick(2);
        nrst = 1'b1;
        hits = 0;
        repeat (TW + 20) begin
            tick(1);
            if (bus.sram_valid === 1'b1) hits++;
        end
        chk("mrst_no_issue", 32'(hits),  32'd0);
        chk("mrst_level_0",  32'(level), 32'd0);

`ifdef SRAM_REQ_QUEUE_STATS_EN
        chk("st_rst_wr", 32'(wr_cnt), 32'd0);
        chk("st_rst_rd", 32'(rd_cnt), 32'd0);
        bus.rsp_ready = 1'b1;
        do_txn(15'h0300, 8'h01, 1'b0);
        do_txn(15'h0301, 8'h02, 1'b1);
        do_txn(15'h0302, 8'h03, 1'b0);
        do_txn(15'h0303, 8'h04, 1'b1);
        do_txn(15'h0304, 8'h05, 1'b0);
        chk("st_wr_count", 32'(wr_cnt), 32'd3);
        chk("st_rd_count", 32'(rd_cnt), 32'd2);
        force dut.wr_count_q = 16'hFFFF;
        tick(1);
        release dut.wr_count_q;
        tick(1);
        chk("st_preload", 32'(wr_cnt), 32'hFFFF);
        do_txn(15'h0305, 8'h06, 1'b0);
        chk("st_wr_wrap", 32'(wr_cnt), 32'd0);
        chk("st_rd_keep", 32'(rd_cnt), 32'd2);
        bus.rsp_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
